// File: rtl/irq_controller.sv
// Prioritised interrupt controller feeding the Beta irq input: synchronises and edge-detects
// peripheral lines, latches pending requests and presents one at a time with its handler vector.
module irq_controller #(
    parameter int          NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h8000_0008,
    parameter logic [31:0] VEC_STRIDE = 32'd4,
    localparam int         IDW        = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               supervisor,
    input  logic               instr_boundary,
    input  logic               eoi,
    input  logic [IDW-1:0]     eoi_id,
    output logic               irq,
    output logic [31:0]        irq_vec,
    output logic [IDW-1:0]     irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nx;
    logic [NUM_SRC-1:0] sync1, sync2, prev;
    logic [NUM_SRC-1:0] rise, eligible, clr;
    logic [IDW-1:0]     winner;
    logic               any_eligible;
    logic               ack;
    logic               irq_nx, busy_nx;
    logic [IDW-1:0]     id_nx;
    logic [31:0]        vec_nx;

    // Two-flop synchroniser followed by a previous-value stage for rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise         = sync2 & ~prev;
    assign eligible     = pending & irq_mask;
    assign any_eligible = |eligible;
    assign clr          = ack ? (NUM_SRC'(1) << irq_id) : '0;

    // Fixed priority: lowest index wins
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDW'(i);
        end
    end

    // A new edge arriving in the ack cycle keeps the source pending (set wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
            irq_vec <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            irq     <= irq_nx;
            irq_id  <= id_nx;
            irq_vec <= vec_nx;
            busy    <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        irq_nx   = irq;
        id_nx    = irq_id;
        vec_nx   = irq_vec;
        busy_nx  = busy;
        ack      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_eligible && !supervisor) begin
                    state_nx = REQ;
                    irq_nx   = 1'b1;
                    id_nx    = winner;
                    vec_nx   = VEC_BASE + VEC_STRIDE * 32'(winner);
                end
            end
            // Committed request stays frozen until the control logic takes it
            REQ: begin
                if (instr_boundary) begin
                    state_nx = SERVICE;
                    irq_nx   = 1'b0;
                    busy_nx  = 1'b1;
                    ack      = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi && (eoi_id == irq_id)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
